pio_byte_link: RTL and testbench



---
 rtl/pio_link_pkg.sv | 14 +
 rtl/byte_fifo.sv | 59 +++++
 rtl/pio_byte_link.sv | 176 +++++++++++++++++
 tb/tb_pio_byte_link.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_link_pkg.sv
// rtl/pio_link_pkg.sv - shared types and constants for the PIO byte link
package pio_link_pkg;

  // Download handshake states
  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } dl_state_t;

  // Bit positions inside the outsignal PIO
  localparam int OUTSIG_TOGGLE = 0;
  localparam int OUTSIG_LAST   = 1;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - show-ahead FIFO with full/empty/count, push honoured on full when popping
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Flags, accepted operations and next pointer/count values
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    do_pop   = pop & ~empty;
    do_push  = push & (~full | do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop) count_d = count_q + (AW+1)'(1);
    if (do_pop && !do_push) count_d = count_q - (AW+1)'(1);
    rd_data  = mem_q[rd_ptr_q];
    count    = count_q;
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while empty so it is not reset
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/pio_byte_link.sv
// rtl/pio_byte_link.sv - fabric peer of the Nios PIO byte conduit; PIO_LINK_ERR_CNT_EN adds err_count
import pio_link_pkg::*;

module pio_byte_link #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] curbyteout,
  input  logic [1:0] outsignal,
  input  logic       load,
  output logic       readytodownload,
  output logic       instrobe,
  output logic [7:0] curbytein,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       overflow
`ifdef PIO_LINK_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  logic [1:0] osig_q, osig_d;
  logic [7:0] obyte_q, obyte_d;
  logic       tog_q, tog_d;
  logic       load_s_q, load_s_d;
  logic       load_q, load_d;
  logic       rdy_en_q, rdy_en_d;
  logic       rtd_q, rtd_d;
  logic       ovf_q, ovf_d;

  dl_state_t  state_q;
  logic       instrobe_q;
  logic [7:0] curbytein_q;

  logic       detect, drop, load_rise, dl_pop, dl_push;
  logic [8:0] up_head;
  logic       up_full, up_empty;
  logic [AW:0] up_count;
  logic [7:0] dl_head;
  logic       dl_full, dl_empty;
  logic [AW:0] dl_count;

  // Event decode: new upload toggle, dropped byte, load edge, download pop
  always_comb begin
    detect    = osig_q[OUTSIG_TOGGLE] ^ tog_q;
    drop      = detect & up_full & ~rx_ready;
    load_rise = load_s_q & ~load_q;
    dl_pop    = (state_q == IDLE) & load_rise & ~dl_empty;
    tx_ready  = rdy_en_q & (~dl_full | dl_pop);
    dl_push   = tx_valid & tx_ready;
  end

  // Next values for the input stages and status flags
  always_comb begin
    osig_d   = outsignal;
    obyte_d  = curbyteout;
    tog_d    = osig_q[OUTSIG_TOGGLE];
    load_s_d = load;
    load_d   = load_s_q;
    rdy_en_d = 1'b1;
    rtd_d    = (dl_count != '0);
    ovf_d    = ovf_q | drop;
  end

  // Input stages and status registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      osig_q   <= '0;
      obyte_q  <= '0;
      tog_q    <= 1'b0;
      load_s_q <= 1'b0;
      load_q   <= 1'b0;
      rdy_en_q <= 1'b0;
      rtd_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      osig_q   <= osig_d;
      obyte_q  <= obyte_d;
      tog_q    <= tog_d;
      load_s_q <= load_s_d;
      load_q   <= load_d;
      rdy_en_q <= rdy_en_d;
      rtd_q    <= rtd_d;
      ovf_q    <= ovf_d;
    end
  end

  // Four-phase download handshake with registered strobe and byte
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q     <= IDLE;
      instrobe_q  <= 1'b0;
      curbytein_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (dl_pop) begin
            curbytein_q <= dl_head;
            instrobe_q  <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          if (!load_s_q) begin
            instrobe_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  byte_fifo #(.W(9), .DEPTH(DEPTH), .AW(AW)) u_up_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (detect),
    .wr_data ({osig_q[OUTSIG_LAST], obyte_q}),
    .pop     (rx_valid & rx_ready),
    .rd_data (up_head),
    .full    (up_full),
    .empty   (up_empty),
    .count   (up_count)
  );

  byte_fifo #(.W(8), .DEPTH(DEPTH), .AW(AW)) u_dl_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .push    (dl_push),
    .wr_data (tx_data),
    .pop     (dl_pop),
    .rd_data (dl_head),
    .full    (dl_full),
    .empty   (dl_empty),
    .count   (dl_count)
  );

  // Output mapping; the upload head reads as zero while the FIFO is empty
  always_comb begin
    rx_valid        = (up_count != '0);
    {rx_last, rx_data} = up_empty ? 9'h000 : up_head;
    readytodownload = rtd_q;
    instrobe        = instrobe_q;
    curbytein       = curbytein_q;
    overflow        = ovf_q;
  end

`ifdef PIO_LINK_ERR_CNT_EN
  logic [7:0] err_q, err_d;
  logic       ignored;
  logic [8:0] err_sum;

  // Saturating count of dropped uploads and load edges seen on an empty FIFO
  always_comb begin
    ignored   = (state_q == IDLE) & load_rise & dl_empty;
    err_sum   = {1'b0, err_q} + {8'h00, drop} + {8'h00, ignored};
    err_d     = err_sum[8] ? 8'hFF : err_sum[7:0];
    err_count = err_q;
  end

  // Error counter register
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) err_q <= '0;
    else                err_q <= err_d;
  end
`endif

endmodule

// File: tb/tb_pio_byte_link.sv
// tb/tb_pio_byte_link.sv - directed and randomized checks of pio_byte_link against a queue model
module tb_pio_byte_link;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] curbyteout = '0;
  logic [1:0] outsignal = '0;
  logic       load = 1'b0;
  logic       readytodownload, instrobe;
  logic [7:0] curbytein, rx_data;
  logic       rx_last, rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, overflow;
`ifdef PIO_LINK_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] up_m[$];
  logic [7:0] dl_m[$];
  logic       tog = 1'b0;
  logic       ovf_m = 1'b0;
  int         err_m = 0;
  logic [7:0] last_cb = '0;

  pio_byte_link #(.DEPTH(DEPTH)) dut (
    .clk_clk         (clk),
    .reset_reset_n   (rst_n),
    .curbyteout      (curbyteout),
    .outsignal       (outsignal),
    .load            (load),
    .readytodownload (readytodownload),
    .instrobe        (instrobe),
    .curbytein       (curbytein),
    .rx_data         (rx_data),
    .rx_last         (rx_last),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .overflow        (overflow)
`ifdef PIO_LINK_ERR_CNT_EN
    ,
    .err_count       (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_err();
`ifdef PIO_LINK_ERR_CNT_EN
    check("err_count", err_count, (err_m > 255) ? 255 : err_m);
`endif
  endtask

  task automatic up_send(input logic [7:0] b, input logic l);
    curbyteout = b;
    tog = ~tog;
    outsignal = {l, tog};
    if (up_m.size() < DEPTH) up_m.push_back({l, b});
    else begin
      ovf_m = 1'b1;
      err_m++;
    end
    tick(2);
  endtask

  task automatic rx_pop_check();
    logic [8:0] exp;
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (rx_valid) got = 1;
      else tick(1);
    end
    check("rx_wait", got, 1);
    if (got) begin
      exp = up_m.pop_front();
      check("rx_data", rx_data, exp[7:0]);
      check("rx_last", rx_last, exp[8]);
      rx_ready = 1'b1;
      tick(1);
      rx_ready = 1'b0;
    end
  endtask

  task automatic tx_push(input logic [7:0] b);
    bit got = 0;
    tx_data = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (tx_ready) got = 1;
      tick(1);
    end
    tx_valid = 1'b0;
    check("tx_accept", got, 1);
    if (got) dl_m.push_back(b);
  endtask

  task automatic load_pulse();
    logic [7:0] exp;
    bit have = (dl_m.size() != 0);
    load = 1'b1;
    tick(1);
    check("strobe_early", instrobe, 0);
    tick(1);
    if (have) begin
      exp = dl_m.pop_front();
      last_cb = exp;
      check("strobe_rise", instrobe, 1);
      check("curbytein", curbytein, exp);
    end else begin
      err_m++;
      check("strobe_ignored", instrobe, 0);
      check("curbytein_hold", curbytein, last_cb);
    end
    load = 1'b0;
    tick(1);
    check("strobe_hold", instrobe, have);
    tick(1);
    check("strobe_fall", instrobe, 0);
    check("rtd", readytodownload, dl_m.size() != 0);
  endtask

  initial begin
    logic [7:0] nb;
    logic [7:0] exp;

    // Reset state
    tick(3);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rtd", readytodownload, 0);
    check("rst_instrobe", instrobe, 0);
    check("rst_curbytein", curbytein, 0);
    check("rst_overflow", overflow, 0);
    check("rst_tx_ready", tx_ready, 0);
    rst_n = 1'b1;
    #1 check("tx_ready_post_rel", tx_ready, 0);
    tick(1);
    check("tx_ready_one_cycle", tx_ready, 1);
    check_err();

    // Upload 0x5A then 0x3C with end-of-frame, with latency check
    curbyteout = 8'h5A;
    tog = 1'b1;
    outsignal = 2'b01;
    up_m.push_back({1'b0, 8'h5A});
    tick(1);
    check("rx_valid_n1", rx_valid, 0);
    tick(1);
    check("rx_valid_n2", rx_valid, 1);
    up_send(8'h3C, 1'b1);
    rx_pop_check();
    rx_pop_check();
    check("overflow_t1", overflow, ovf_m);

    // Overflow: 17 random uploads with consumer stalled
    for (int i = 0; i < DEPTH + 1; i++) up_send(8'($urandom), 1'($urandom));
    tick(1);
    check("overflow_t2", overflow, ovf_m);
    check_err();
    for (int i = 0; i < DEPTH; i++) rx_pop_check();
    tick(1);
    check("rx_empty_t2", rx_valid, 0);

    // Download two bytes
    tx_push(8'hA1);
    tx_push(8'hB2);
    tick(1);
    check("rtd_t3", readytodownload, 1);
    load_pulse();
    load_pulse();

    // Load on empty download FIFO
    load_pulse();
    check_err();

    // Fill, then pop with a push in the same cycle
    for (int i = 0; i < DEPTH; i++) tx_push(8'($urandom));
    tick(1);
    check("tx_ready_full", tx_ready, 0);
    nb = 8'($urandom);
    tx_data = nb;
    tx_valid = 1'b1;
    load = 1'b1;
    @(negedge clk);
    check("tx_ready_before_edge", tx_ready, 0);
    tick(1);
    @(negedge clk);
    check("tx_ready_pop_cycle", tx_ready, 1);
    tick(1);
    tx_valid = 1'b0;
    exp = dl_m.pop_front();
    last_cb = exp;
    dl_m.push_back(nb);
    check("strobe_t5", instrobe, 1);
    check("curbytein_t5", curbytein, exp);
    check("tx_ready_full_again", tx_ready, 0);
    load = 1'b0;
    tick(2);
    for (int i = 0; i < DEPTH; i++) load_pulse();

    // Reset while presenting with five bytes queued
    for (int i = 0; i < 6; i++) tx_push(8'($urandom));
    load = 1'b1;
    tick(2);
    check("strobe_t6", instrobe, 1);
    rst_n = 1'b0;
    load = 1'b0;
    outsignal = '0;
    #1;
    check("rst6_instrobe", instrobe, 0);
    check("rst6_curbytein", curbytein, 0);
    check("rst6_rtd", readytodownload, 0);
    check("rst6_tx_ready", tx_ready, 0);
    check("rst6_rx_valid", rx_valid, 0);
    check("rst6_rx_data", rx_data, 0);
    check("rst6_overflow", overflow, 0);
    up_m.delete();
    dl_m.delete();
    tog = 1'b0;
    ovf_m = 1'b0;
    err_m = 0;
    last_cb = '0;
    check_err();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    check("rtd_after_rst", readytodownload, 0);
    check("tx_ready_after_rst", tx_ready, 1);
    tx_push(8'h77);
    load_pulse();
    up_send(8'hC3, 1'b0);
    rx_pop_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
